// File: rtl/dcache_way_replacer.sv
// dcache_way_replacer: picks a victim way, writes back dirty lines, refills over a narrow burst bus, invalidates lines.
// Latency: Lookup is 1 cycle; a clean Replace with zero-wait memory finishes in cycle 3+BEAT_COUNT after enable.
// Backpressure: write beats hold on memWriteReady, read beats wait for memReadValid; enable is sampled only in Idle.
// Build option: define DCACHE_REPLACER_WRITEBACK_EN to honour dirty bits (write-back on replace, flush rewrites dirty=0).
`timescale 1ns/1ps

package dcache_way_replacer_pkg;
  typedef enum logic [1:0] {
    CMD_REPLACE       = 2'd0,
    CMD_WRITE_THROUGH = 2'd1,
    CMD_INVALIDATE    = 2'd2
  } CacheCommand;
endpackage

module dcache_way_replacer
  import dcache_way_replacer_pkg::*;
#(
  parameter int LINE_WIDTH     = 128,
  parameter int TAG_WIDTH      = 20,
  parameter int INDEX_WIDTH    = 6,
  parameter int WAY_COUNT      = 4,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           arrayWriteEnable,
  output logic [INDEX_WIDTH-1:0]         arrayIndex,
  output logic [$clog2(WAY_COUNT)-1:0]   arrayWay,
  output logic                           arrayWriteValid,
  output logic                           arrayWriteDirty,
  output logic [TAG_WIDTH-1:0]           arrayWriteTag,
  output logic [LINE_WIDTH-1:0]          arrayWriteData,
  input  logic [WAY_COUNT-1:0]           arrayReadValid,
  input  logic [WAY_COUNT-1:0]           arrayReadDirty,
  input  logic [WAY_COUNT*TAG_WIDTH-1:0] arrayReadTag,
  input  logic [LINE_WIDTH-1:0]          arrayReadData,
  output logic [MEM_ADDR_WIDTH-1:0]      memAddr,
  output logic                           memReadEnable,
  input  logic                           memReadValid,
  input  logic [MEM_DATA_WIDTH-1:0]      memReadValue,
  output logic                           memWriteEnable,
  input  logic                           memWriteReady,
  output logic [MEM_DATA_WIDTH-1:0]      memWriteValue,
  output logic                           done,
  output logic [$clog2(WAY_COUNT)-1:0]   doneWay,
  input  logic                           enable,
  input  CacheCommand                    command,
  input  logic [MEM_ADDR_WIDTH-1:0]      commandAddr
);

  localparam int WAY_W      = $clog2(WAY_COUNT);
  localparam int BEAT_COUNT = LINE_WIDTH / MEM_DATA_WIDTH;
  localparam int BEAT_W     = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEAT_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_READ_LINE,
    S_WRITE_MEMORY,
    S_INV_FOR_REPLACE,
    S_READ_MEMORY,
    S_WRITE_CACHE,
    S_INVALIDATE
  } state_e;

  state_e                state_q, state_d;
  CacheCommand           cmd_q, cmd_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [TAG_WIDTH-1:0]  vtag_q, vtag_d;

  logic [INDEX_WIDTH-1:0] cmd_index;
  logic [TAG_WIDTH-1:0]   cmd_tag;
  assign cmd_index = commandAddr[INDEX_WIDTH-1:0];
  assign cmd_tag   = commandAddr[INDEX_WIDTH +: TAG_WIDTH];

  // Only valid lines count as dirty; without write-back support dirty bits are never looked at.
  logic [WAY_COUNT-1:0] way_dirty;
`ifdef DCACHE_REPLACER_WRITEBACK_EN
  assign way_dirty = arrayReadValid & arrayReadDirty;
`else
  logic unused_dirty;
  assign way_dirty    = '0;
  assign unused_dirty = ^arrayReadDirty;
`endif

  // Tag compare and lowest-invalid search over the registered array outputs; lowest index wins both.
  logic             hit, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way;
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAY_COUNT; w++) begin
      if (!hit && arrayReadValid[w] && (arrayReadTag[w*TAG_WIDTH +: TAG_WIDTH] == cmd_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !arrayReadValid[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  logic [WAY_W-1:0]     sel_way;
  logic                 sel_dirty;
  logic [TAG_WIDTH-1:0] sel_tag;
  logic                 last_beat;
  logic [BEAT_W-1:0]    beat_next;
  assign sel_way   = hit ? hit_way : (inv_found ? inv_way : victim_q);
  assign sel_dirty = way_dirty[sel_way];
  assign sel_tag   = arrayReadTag[int'(sel_way)*TAG_WIDTH +: TAG_WIDTH];
  assign last_beat = (beat_q == LAST_BEAT);
  assign beat_next = last_beat ? '0 : beat_q + BEAT_W'(1);

  // Next-state and completion decode for the whole command sequence.
  logic done_c;
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    line_d   = line_q;
    victim_d = victim_q;
    way_d    = way_q;
    beat_d   = beat_q;
    vtag_d   = vtag_q;
    done_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          cmd_d   = command;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        way_d  = sel_way;
        vtag_d = sel_tag;
        case (cmd_q)
          CMD_REPLACE: begin
            // Round-robin pointer only moves when it actually supplied the way.
            if (!hit && !inv_found) victim_d = victim_q + WAY_W'(1);
            state_d = (!hit && sel_dirty) ? S_READ_LINE : S_INV_FOR_REPLACE;
          end
          CMD_WRITE_THROUGH: begin
`ifdef DCACHE_REPLACER_WRITEBACK_EN
            if (hit && sel_dirty) state_d = S_READ_LINE;
`else
            if (hit) state_d = S_READ_LINE;
`endif
            else begin
              done_c  = 1'b1;
              state_d = S_IDLE;
            end
          end
          CMD_INVALIDATE: begin
            if (hit) state_d = S_INVALIDATE;
            else begin
              done_c  = 1'b1;
              state_d = S_IDLE;
            end
          end
          default: begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_READ_LINE: begin
        line_d  = arrayReadData;
        state_d = S_WRITE_MEMORY;
      end
      S_WRITE_MEMORY: begin
        if (memWriteReady) begin
          beat_d = beat_next;
          if (last_beat) begin
            if (cmd_q == CMD_REPLACE) state_d = S_INV_FOR_REPLACE;
            else begin
`ifdef DCACHE_REPLACER_WRITEBACK_EN
              state_d = S_WRITE_CACHE;
`else
              done_c  = 1'b1;
              state_d = S_IDLE;
`endif
            end
          end
        end
      end
      S_INV_FOR_REPLACE: state_d = S_READ_MEMORY;
      S_READ_MEMORY: begin
        if (memReadValid) begin
          line_d[int'(beat_q)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = memReadValue;
          beat_d = beat_next;
          if (last_beat) state_d = S_WRITE_CACHE;
        end
      end
      S_WRITE_CACHE, S_INVALIDATE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= CMD_REPLACE;
      line_q   <= '0;
      victim_q <= '0;
      way_q    <= '0;
      beat_q   <= '0;
      vtag_q   <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      line_q   <= line_d;
      victim_q <= victim_d;
      way_q    <= way_d;
      beat_q   <= beat_d;
      vtag_q   <= vtag_d;
    end
  end

  // The way is driven during Lookup so the line read lands in ReadLine.
  assign arrayIndex       = cmd_index;
  assign arrayWay         = (state_q == S_LOOKUP) ? sel_way : way_q;
  assign arrayWriteEnable = (state_q == S_WRITE_CACHE) || (state_q == S_INVALIDATE) ||
                            (state_q == S_INV_FOR_REPLACE);
  assign arrayWriteValid  = (state_q == S_WRITE_CACHE);
  assign arrayWriteDirty  = 1'b0;
  assign arrayWriteTag    = (state_q == S_WRITE_CACHE) ? cmd_tag : '0;
  assign arrayWriteData   = (state_q == S_WRITE_CACHE) ? line_q : '0;
  assign memAddr          = (state_q == S_WRITE_MEMORY) ? MEM_ADDR_WIDTH'({vtag_q, cmd_index}) : commandAddr;
  assign memReadEnable    = (state_q == S_READ_MEMORY);
  assign memWriteEnable   = (state_q == S_WRITE_MEMORY);
  assign memWriteValue    = line_q[int'(beat_q)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
  assign done             = done_c;
  assign doneWay          = done_c ? arrayWay : '0;

endmodule

// File: tb/tb_dcache_way_replacer.sv
// Directed bench for dcache_way_replacer with a behavioural tag/data array and burst memory.
// Array reads return one cycle after index/way; memory read returns a known beat pattern with zero wait.
// Write-ready can be stalled on a chosen beat to exercise write-back backpressure.
`timescale 1ns/1ps

module tb_dcache_way_replacer;
  import dcache_way_replacer_pkg::*;

  localparam int LW = 128, TW = 20, IW = 6, WC = 4, MW = 32, AW = 26;

  logic clk = 1'b0;
  logic rst;
  logic arrayWriteEnable, arrayWriteValid, arrayWriteDirty;
  logic [IW-1:0] arrayIndex;
  logic [1:0] arrayWay, doneWay;
  logic [TW-1:0] arrayWriteTag;
  logic [LW-1:0] arrayWriteData, arrayReadData;
  logic [WC-1:0] arrayReadValid, arrayReadDirty;
  logic [WC*TW-1:0] arrayReadTag;
  logic [AW-1:0] memAddr, commandAddr;
  logic memReadEnable, memReadValid, memWriteEnable, memWriteReady, done, enable;
  logic [MW-1:0] memReadValue, memWriteValue;
  CacheCommand command;

  dcache_way_replacer dut (
    .clk(clk), .rst(rst),
    .arrayWriteEnable(arrayWriteEnable), .arrayIndex(arrayIndex), .arrayWay(arrayWay),
    .arrayWriteValid(arrayWriteValid), .arrayWriteDirty(arrayWriteDirty),
    .arrayWriteTag(arrayWriteTag), .arrayWriteData(arrayWriteData),
    .arrayReadValid(arrayReadValid), .arrayReadDirty(arrayReadDirty),
    .arrayReadTag(arrayReadTag), .arrayReadData(arrayReadData),
    .memAddr(memAddr), .memReadEnable(memReadEnable), .memReadValid(memReadValid),
    .memReadValue(memReadValue), .memWriteEnable(memWriteEnable), .memWriteReady(memWriteReady),
    .memWriteValue(memWriteValue), .done(done), .doneWay(doneWay),
    .enable(enable), .command(command), .commandAddr(commandAddr)
  );

  always #5 clk = ~clk;

  // Array model and event logs
  logic          m_valid [64][4];
  logic          m_dirty [64][4];
  logic [TW-1:0] m_tag   [64][4];
  logic [LW-1:0] m_data  [64][4];
  logic [AW-1:0] wb_addr[$];
  logic [MW-1:0] wb_val[$];
  int rd_total = 0, aw_total = 0, done_total = 0, mem_en_cycles = 0;
  logic [1:0] aw_way;
  logic aw_valid, aw_dirty;
  logic [1:0] rd_beat = 2'd0, wr_beat = 2'd0, stall_beat = 2'd1;
  int stall_left = 0;
  logic [IW-1:0] p_idx = '0;
  logic [1:0] p_way = '0;

  int n_vec = 0, n_miss = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk(input logic [TW-1:0] t, input logic [IW-1:0] i);
    return {t, i};
  endfunction

  // Refill pattern the memory model returns: beat k = {4'hD, k, line address}
  function automatic logic [LW-1:0] exp_line(input logic [AW-1:0] a);
    return {4'hD, 2'd3, a, 4'hD, 2'd2, a, 4'hD, 2'd1, a, 4'hD, 2'd0, a};
  endfunction

  // Environment: drive memory handshakes at negedge, log at negedge+1, refresh array reads after posedge.
  initial begin
    memReadValid = 1'b0; memReadValue = '0; memWriteReady = 1'b1;
    arrayReadValid = '0; arrayReadDirty = '0; arrayReadTag = '0; arrayReadData = '0;
    forever begin
      @(negedge clk);
      memReadValid = memReadEnable;
      memReadValue = {4'hD, rd_beat, memAddr};
      if (memWriteEnable && wr_beat == stall_beat && stall_left > 0) begin
        memWriteReady = 1'b0;
        stall_left--;
      end else memWriteReady = 1'b1;
      #1;
      p_idx = arrayIndex;
      p_way = arrayWay;
      if (!rst) begin
        rd_beat = 2'd0;
        wr_beat = 2'd0;
      end else begin
        if (memReadEnable && memReadValid) begin rd_beat++; rd_total++; end
        if (memWriteEnable && memWriteReady) begin
          wb_addr.push_back(memAddr);
          wb_val.push_back(memWriteValue);
          wr_beat++;
        end
        if (memReadEnable || memWriteEnable) mem_en_cycles++;
        if (done) done_total++;
        if (arrayWriteEnable) begin
          m_valid[arrayIndex][arrayWay] = arrayWriteValid;
          m_dirty[arrayIndex][arrayWay] = arrayWriteDirty;
          m_tag[arrayIndex][arrayWay]   = arrayWriteTag;
          m_data[arrayIndex][arrayWay]  = arrayWriteData;
          aw_way = arrayWay; aw_valid = arrayWriteValid; aw_dirty = arrayWriteDirty;
          aw_total++;
        end
      end
      @(posedge clk);
      #1;
      for (int w = 0; w < WC; w++) begin
        arrayReadValid[w] = m_valid[p_idx][w];
        arrayReadDirty[w] = m_dirty[p_idx][w];
        arrayReadTag[w*TW +: TW] = m_tag[p_idx][w];
      end
      arrayReadData = m_data[p_idx][p_way];
    end
  end

  task automatic set_way(input logic [IW-1:0] i, input int w, input logic v, input logic d,
                         input logic [TW-1:0] t, input logic [LW-1:0] dat);
    m_valid[i][w] = v; m_dirty[i][w] = d; m_tag[i][w] = t; m_data[i][w] = dat;
  endtask

  // Issue one command; lat is the cycle (enable cycle = 0) in which done was seen.
  task automatic run_cmd(input CacheCommand c, input logic [AW-1:0] a, output int lat, output logic [1:0] way);
    @(negedge clk);
    enable = 1'b1; command = c; commandAddr = a;
    lat = 0; way = 2'd0;
    while (lat < 100) begin
      @(negedge clk);
      enable = 1'b0;
      lat++;
      #2;
      if (done) begin way = doneWay; break; end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int lat, rd0, aw0, dn0, wb0, me0;
  logic [1:0] way;
  logic [1:0] exp_ways [5];
  logic [LW-1:0] d0, d1;

  initial begin
    for (int i = 0; i < 64; i++)
      for (int w = 0; w < WC; w++) set_way(6'(i), w, 1'b0, 1'b0, '0, '0);
    rst = 1'b0; enable = 1'b0; command = CMD_REPLACE; commandAddr = mk(20'hABC, 6'd5);
    exp_ways = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    d0 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    d1 = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;

    // Reset state
    @(negedge clk); @(negedge clk); #2;
    check_val("rst_ctrl", 128'({arrayWriteEnable, memReadEnable, memWriteEnable, done,
                                arrayWriteValid, arrayWriteDirty}), 128'd0);
    check_val("rst_ways", 128'({arrayWay, doneWay}), 128'd0);
    check_val("rst_index", 128'(arrayIndex), 128'd5);
    check_val("rst_memaddr", 128'(memAddr), 128'h2AF05);
    check_val("rst_wdata", 128'({arrayWriteTag, memWriteValue}), 128'd0);
    check_val("rst_wline", arrayWriteData, 128'd0);
    @(negedge clk); rst = 1'b1;

    // Replace on an empty set fills way 0
    aw0 = aw_total; rd0 = rd_total; dn0 = done_total;
    run_cmd(CMD_REPLACE, mk(20'hABC, 6'd5), lat, way);
    check_val("fill_lat", 128'(lat), 128'd7);
    check_val("fill_way", 128'(way), 128'd0);
    check_val("fill_valid_dirty", 128'({m_valid[5][0], m_dirty[5][0]}), 128'b10);
    check_val("fill_tag", 128'(m_tag[5][0]), 128'hABC);
    check_val("fill_data", m_data[5][0], exp_line(mk(20'hABC, 6'd5)));
    check_val("fill_arr_writes", 128'(aw_total - aw0), 128'd2);
    check_val("fill_beats", 128'(rd_total - rd0), 128'd4);
    @(negedge clk);
    check_val("fill_done_once", 128'(done_total - dn0), 128'd1);

    // Round-robin over a full clean set
    pulse_reset();
    for (int w = 0; w < WC; w++) set_way(6'd7, w, 1'b1, 1'b0, 20'(32'h100 + w), '0);
    for (int k = 0; k < 5; k++) begin
      run_cmd(CMD_REPLACE, mk(20'(32'h200 + k), 6'd7), lat, way);
      check_val("rr_way", 128'(way), 128'(exp_ways[k]));
      check_val("rr_lat", 128'(lat), 128'd7);
    end

    // Dirty victim, write-ready stalled 2 cycles on beat 1
    pulse_reset();
    set_way(6'd9, 0, 1'b1, 1'b1, 20'h12, d0);
    for (int w = 1; w < WC; w++) set_way(6'd9, w, 1'b1, 1'b0, 20'(32'h20 + w), '0);
    wb0 = wb_addr.size(); dn0 = done_total;
    stall_beat = 2'd1; stall_left = 2;
    run_cmd(CMD_REPLACE, mk(20'h55, 6'd9), lat, way);
    stall_left = 0;
    check_val("dv_way", 128'(way), 128'd0);
    check_val("dv_tag", 128'(m_tag[9][0]), 128'h55);
    check_val("dv_dirty", 128'(m_dirty[9][0]), 128'd0);
`ifdef DCACHE_REPLACER_WRITEBACK_EN
    check_val("dv_lat", 128'(lat), 128'd14);
    check_val("dv_wb_beats", 128'(wb_addr.size() - wb0), 128'd4);
    if (wb_addr.size() - wb0 == 4) begin
      check_val("dv_wb_addr0", 128'(wb_addr[wb0]), 128'h489);
      check_val("dv_wb_addr3", 128'(wb_addr[wb0+3]), 128'h489);
      check_val("dv_wb_beat0", 128'(wb_val[wb0]), 128'h76543210);
      check_val("dv_wb_beat1", 128'(wb_val[wb0+1]), 128'hFEDCBA98);
      check_val("dv_wb_beat2", 128'(wb_val[wb0+2]), 128'h89ABCDEF);
      check_val("dv_wb_beat3", 128'(wb_val[wb0+3]), 128'h01234567);
    end
`else
    check_val("dv_lat", 128'(lat), 128'd7);
    check_val("dv_wb_beats", 128'(wb_addr.size() - wb0), 128'd0);
`endif
    @(negedge clk);
    check_val("dv_done_once", 128'(done_total - dn0), 128'd1);

    // WriteThrough hit on a dirty line, then a miss
    set_way(6'd11, 1, 1'b1, 1'b1, 20'h77, d1);
    wb0 = wb_addr.size(); aw0 = aw_total;
    run_cmd(CMD_WRITE_THROUGH, mk(20'h77, 6'd11), lat, way);
    check_val("wt_way", 128'(way), 128'd1);
    check_val("wt_wb_beats", 128'(wb_addr.size() - wb0), 128'd4);
    if (wb_addr.size() - wb0 == 4) begin
      check_val("wt_wb_addr", 128'(wb_addr[wb0+2]), 128'h1DCB);
      check_val("wt_wb_beat0", 128'(wb_val[wb0]), 128'hCAFE0000);
      check_val("wt_wb_beat3", 128'(wb_val[wb0+3]), 128'hCAFE0003);
    end
`ifdef DCACHE_REPLACER_WRITEBACK_EN
    check_val("wt_lat", 128'(lat), 128'd7);
    check_val("wt_arr_writes", 128'(aw_total - aw0), 128'd1);
    check_val("wt_line_state", 128'({m_valid[11][1], m_dirty[11][1], m_tag[11][1]}), 128'h200077);
    check_val("wt_line_data", m_data[11][1], d1);
`else
    check_val("wt_lat", 128'(lat), 128'd6);
    check_val("wt_arr_writes", 128'(aw_total - aw0), 128'd0);
`endif
    me0 = mem_en_cycles; wb0 = wb_addr.size();
    run_cmd(CMD_WRITE_THROUGH, mk(20'h78, 6'd11), lat, way);
    check_val("wtm_lat", 128'(lat), 128'd1);
    check_val("wtm_mem_cycles", 128'(mem_en_cycles - me0), 128'd0);

    // Invalidate hit way 2, then a miss
    for (int w = 0; w < WC; w++) set_way(6'd13, w, 1'b1, 1'b0, 20'(32'h30 + w), '0);
    set_way(6'd13, 2, 1'b1, 1'b1, 20'h40, d0);
    aw0 = aw_total;
    run_cmd(CMD_INVALIDATE, mk(20'h40, 6'd13), lat, way);
    check_val("inv_lat", 128'(lat), 128'd2);
    check_val("inv_way", 128'(way), 128'd2);
    check_val("inv_writes", 128'(aw_total - aw0), 128'd1);
    check_val("inv_write_fields", 128'({aw_way, aw_valid, aw_dirty}), 128'b1000);
    check_val("inv_model_valid", 128'({m_valid[13][2], m_valid[13][3]}), 128'b01);
    aw0 = aw_total;
    run_cmd(CMD_INVALIDATE, mk(20'h41, 6'd13), lat, way);
    check_val("invm_lat", 128'(lat), 128'd1);
    check_val("invm_writes", 128'(aw_total - aw0), 128'd0);

    // Reset during refill beat 2
    rd0 = rd_total;
    @(negedge clk);
    enable = 1'b1; command = CMD_REPLACE; commandAddr = mk(20'h321, 6'd20);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      enable = 1'b0;
      #2;
      if (rd_total - rd0 == 3) break;
    end
    check_val("mr_reach_beat2", 128'(rd_total - rd0), 128'd3);
    aw0 = aw_total; dn0 = done_total;
    rst = 1'b0;
    #1;
    check_val("mr_rd_en", 128'({memReadEnable, memWriteEnable, arrayWriteEnable, done}), 128'd0);
    check_val("mr_index", 128'(arrayIndex), 128'd20);
    @(negedge clk); @(negedge clk); #2;
    check_val("mr_no_write", 128'(aw_total - aw0), 128'd0);
    rst = 1'b1;
    check_val("mr_no_done", 128'(done_total - dn0), 128'd0);
    run_cmd(CMD_REPLACE, mk(20'h321, 6'd20), lat, way);
    check_val("mr_after_lat", 128'(lat), 128'd7);
    check_val("mr_after_way", 128'(way), 128'd0);
    check_val("mr_after_data", m_data[20][0], exp_line(mk(20'h321, 6'd20)));

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
